// File: rtl/error_flip_corrector_pkg.sv
// Shared types for the error flip corrector and the upstream detector:
// per-lane error codes, corrector state encoding, and code decode helpers.
package error_flip_corrector_pkg;

  // Detector decision per lane.
  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,  // no flip
    ERR_CUR  = 2'd1,  // flip this lane
    ERR_PREV = 2'd2,  // flip the lane before this one
    ERR_BOTH = 2'd3   // flip this lane and the one before it
  } err_code_e;

  // Corrector holds at most one frame while waiting for its successor.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // True when the code requests a flip of its own lane.
  function automatic logic hits_cur(input logic [1:0] code);
    return (code == ERR_CUR) || (code == ERR_BOTH);
  endfunction

  // True when the code requests a flip of the preceding lane.
  function automatic logic hits_prev(input logic [1:0] code);
    return (code == ERR_PREV) || (code == ERR_BOTH);
  endfunction

endpackage

// File: rtl/error_flip_corrector_flip_mask_gen.sv
// Turns one frame's per-lane error codes into an own-frame flip mask plus a
// carry bit that targets the last lane of the previous frame.
module flip_mask_gen
  import error_flip_corrector_pkg::*;
#(
  parameter int width = 16
) (
  input  logic [1:0]       err_pos_i [width],
  input  logic             en_i,
  output logic [width-1:0] own_mask_o,
  output logic             carry_o
);

  // OR together "this lane" and "next lane points back" requests per lane.
  always_comb begin
    own_mask_o = '0;
    carry_o    = 1'b0;
    if (en_i) begin
      for (int i = 0; i < width - 1; i++) begin
        own_mask_o[i] = hits_cur(err_pos_i[i]) | hits_prev(err_pos_i[i+1]);
      end
      own_mask_o[width-1] = hits_cur(err_pos_i[width-1]);
      carry_o             = hits_prev(err_pos_i[0]);
    end
  end

endmodule

// File: rtl/error_flip_corrector.sv
// Error flip corrector: holds each frame until its successor arrives (or a
// flush), so the successor's lane-0 "flip previous lane" request can reach
// the held frame's last bit, then emits the corrected frame for one cycle.
// Handshake: in_valid has no backpressure; every cycle it is high a frame is
// accepted. out_valid is a single-cycle pulse per emitted frame.
module error_flip_corrector
  import error_flip_corrector_pkg::*;
#(
  parameter int width     = 16,
  parameter int cnt_width = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       bits_in [width],
  input  logic [1:0]                 err_pos [width],
  input  logic                       en_corr,
  input  logic                       flush,
  input  logic                       clr_cnt,
  output logic                       out_valid,
  output logic                       bits_out [width],
  output logic [width-1:0]           flip_mask,
  output logic [$clog2(width+1)-1:0] flip_count,
  output logic [cnt_width-1:0]       total_flips,
  output state_e                     dbg_state
);

  localparam int CW = $clog2(width + 1);
  localparam int SW = ((cnt_width + 1) > CW) ? (cnt_width + 2) : (CW + 1);

  state_e                 state_q, state_d;
  logic [width-1:0]       held_bits_q, held_bits_d;
  logic [width-1:0]       held_mask_q, held_mask_d;
  logic                   out_valid_q;
  logic [width-1:0]       bits_out_q;
  logic [width-1:0]       flip_mask_q;
  logic [CW-1:0]          flip_count_q;
  logic [cnt_width-1:0]   total_q, total_d;

  logic [width-1:0]       in_vec;
  logic [width-1:0]       own_mask;
  logic                   carry;
  logic                   emit;
  logic [width-1:0]       emit_mask;
  logic [CW-1:0]          emit_count;
  logic [SW-1:0]          sum;

  flip_mask_gen #(.width(width)) u_mask_gen (
    .err_pos_i  (err_pos),
    .en_i       (en_corr),
    .own_mask_o (own_mask),
    .carry_o    (carry)
  );

  // Pack the incoming frame and unpack the registered output frame.
  always_comb begin
    in_vec = '0;
    for (int i = 0; i < width; i++) begin
      in_vec[i]   = bits_in[i];
      bits_out[i] = bits_out_q[i];
    end
  end

  // Next-state: accept frames, decide when the held frame is emitted.
  always_comb begin
    state_d     = state_q;
    held_bits_d = held_bits_q;
    held_mask_d = held_mask_q;
    emit        = 1'b0;
    emit_mask   = '0;
    case (state_q)
      ST_EMPTY: begin
        if (in_valid) begin
          state_d     = ST_HOLD;
          held_bits_d = in_vec;
          held_mask_d = own_mask;
        end
      end
      ST_HOLD: begin
        if (in_valid) begin
          emit        = 1'b1;
          emit_mask   = held_mask_q | {carry, {(width-1){1'b0}}};
          held_bits_d = in_vec;
          held_mask_d = own_mask;
        end else if (flush) begin
          emit        = 1'b1;
          emit_mask   = held_mask_q;
          state_d     = ST_EMPTY;
          held_bits_d = '0;
          held_mask_d = '0;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Popcount of the emitted mask and saturating running total.
  always_comb begin
    emit_count = '0;
    for (int i = 0; i < width; i++) begin
      emit_count = emit_count + CW'(emit_mask[i]);
    end
    sum = SW'(total_q) + SW'(emit_count);
    total_d = total_q;
    if (clr_cnt) begin
      total_d = '0;
    end else if (emit) begin
      if (sum > SW'({cnt_width{1'b1}})) total_d = {cnt_width{1'b1}};
      else                              total_d = sum[cnt_width-1:0];
    end
  end

  // State, held frame, registered outputs and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      held_bits_q  <= '0;
      held_mask_q  <= '0;
      out_valid_q  <= 1'b0;
      bits_out_q   <= '0;
      flip_mask_q  <= '0;
      flip_count_q <= '0;
      total_q      <= '0;
    end else begin
      state_q     <= state_d;
      held_bits_q <= held_bits_d;
      held_mask_q <= held_mask_d;
      out_valid_q <= emit;
      total_q     <= total_d;
      if (emit) begin
        bits_out_q   <= held_bits_q ^ emit_mask;
        flip_mask_q  <= emit_mask;
        flip_count_q <= emit_count;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign flip_mask   = flip_mask_q;
  assign flip_count  = flip_count_q;
  assign total_flips = total_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_error_flip_corrector.sv
// Bench for error_flip_corrector: directed literal cases plus randomized
// traffic checked every cycle against a frame-level model. Two instances
// share stimulus; one uses a 4-bit counter to exercise saturation.
module tb_error_flip_corrector;
  import error_flip_corrector_pkg::*;

  localparam int W  = 16;
  localparam int CW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, en_corr = 1'b1, flush = 1'b0, clr_cnt = 1'b0;
  logic       bits_in [W];
  logic [1:0] err_pos [W];

  logic          ov_a, ov_b;
  logic          bo_a [W];
  logic          bo_b [W];
  logic [W-1:0]  fm_a, fm_b;
  logic [CW-1:0] fc_a, fc_b;
  logic [15:0]   tf_a;
  logic [3:0]    tf_b;
  state_e        st_a, st_b;

  error_flip_corrector #(.width(W), .cnt_width(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .bits_in(bits_in),
    .err_pos(err_pos), .en_corr(en_corr), .flush(flush), .clr_cnt(clr_cnt),
    .out_valid(ov_a), .bits_out(bo_a), .flip_mask(fm_a), .flip_count(fc_a),
    .total_flips(tf_a), .dbg_state(st_a)
  );

  error_flip_corrector #(.width(W), .cnt_width(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .bits_in(bits_in),
    .err_pos(err_pos), .en_corr(en_corr), .flush(flush), .clr_cnt(clr_cnt),
    .out_valid(ov_b), .bits_out(bo_b), .flip_mask(fm_b), .flip_count(fc_b),
    .total_flips(tf_b), .dbg_state(st_b)
  );

  // ---------------- scoring ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic a [W]);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) v = v | (W'(a[i]) << i);
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  // A frame is held until something follows it; the follower's requests
  // aimed "one lane back" from lane 0 land on the held frame's top bit.
  logic          m_have = 1'b0;
  logic [W-1:0]  m_bits = '0, m_mask = '0;
  logic          e_valid = 1'b0;
  logic [W-1:0]  e_bits = '0, e_mask = '0;
  int            e_count = 0, e_tot16 = 0, e_tot4 = 0;

  always @(posedge clk or posedge rst) begin
    logic [W-1:0] own;
    logic         back;
    logic [W-1:0] fm;
    logic         fire;
    if (rst) begin
      m_have = 1'b0; m_bits = '0; m_mask = '0;
      e_valid = 1'b0; e_bits = '0; e_mask = '0;
      e_count = 0; e_tot16 = 0; e_tot4 = 0;
    end else begin
      own  = '0;
      back = 1'b0;
      fm   = '0;
      fire = 1'b0;
      if (en_corr) begin
        for (int i = 0; i < W; i++) begin
          if (err_pos[i] == 2'd1 || err_pos[i] == 2'd3) own = own | (W'(1) << i);
          if (err_pos[i] == 2'd2 || err_pos[i] == 2'd3) begin
            if (i == 0) back = 1'b1;
            else        own = own | (W'(1) << (i - 1));
          end
        end
      end
      if (in_valid) begin
        if (m_have) begin
          fire = 1'b1;
          fm   = m_mask | (back ? (W'(1) << (W - 1)) : W'(0));
        end
      end else if (flush && m_have) begin
        fire = 1'b1;
        fm   = m_mask;
      end
      e_valid = fire;
      if (fire) begin
        e_bits  = m_bits ^ fm;
        e_mask  = fm;
        e_count = $countones(fm);
        e_tot16 = (e_tot16 + e_count > 65535) ? 65535 : e_tot16 + e_count;
        e_tot4  = (e_tot4 + e_count > 15) ? 15 : e_tot4 + e_count;
      end
      if (clr_cnt) begin
        e_tot16 = 0;
        e_tot4  = 0;
      end
      if (in_valid) begin
        m_bits = pack(bits_in);
        m_mask = own;
        m_have = 1'b1;
      end else if (flush && m_have) begin
        m_have = 1'b0;
      end
    end
  end

  // Compare both instances to the model on every falling edge.
  always @(negedge clk) begin
    chk("out_valid_a", 32'(ov_a), 32'(e_valid));
    chk("out_valid_b", 32'(ov_b), 32'(e_valid));
    chk("bits_out_a", 32'(pack(bo_a)), 32'(e_bits));
    chk("bits_out_b", 32'(pack(bo_b)), 32'(e_bits));
    chk("flip_mask_a", 32'(fm_a), 32'(e_mask));
    chk("flip_count_a", 32'(fc_a), 32'(e_count));
    chk("flip_count_b", 32'(fc_b), 32'(e_count));
    chk("total_a", 32'(tf_a), 32'(e_tot16));
    chk("total_b", 32'(tf_b), 32'(e_tot4));
    chk("state_a", 32'(st_a == ST_HOLD), 32'(m_have));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_codes();
    for (int i = 0; i < W; i++) err_pos[i] = 2'd0;
  endtask

  task automatic set_bits(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) bits_in[i] = v[i];
  endtask

  task automatic send(input logic [W-1:0] v, input logic en);
    set_bits(v);
    en_corr  = en;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    en_corr  = 1'b1;
    clear_codes();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_codes();
    set_bits('0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_valid", 32'(ov_a), 32'd0);
    chk("rst_total", 32'(tf_a), 32'd0);
    chk("rst_bits", 32'(pack(bo_a)), 32'd0);
    chk("rst_state", 32'(st_a == ST_EMPTY), 32'd1);

    // Clean frames: A emerges right after B is accepted
    send(16'h00FF, 1'b1);
    chk("clean_no_early_out", 32'(ov_a), 32'd0);
    send(16'h0000, 1'b1);
    chk("clean_valid", 32'(ov_a), 32'd1);
    chk("clean_bits", 32'(pack(bo_a)), 32'h00FF);
    chk("clean_mask", 32'(fm_a), 32'h0);
    chk("clean_count", 32'(fc_a), 32'd0);
    tick();
    chk("clean_pulse_ends", 32'(ov_a), 32'd0);
    chk("clean_bits_hold", 32'(pack(bo_a)), 32'h00FF);
    do_flush();
    tick();

    // Own-lane flip plus carry from successor's lane 0
    err_pos[5] = 2'd1;
    send(16'h0000, 1'b1);
    err_pos[0] = 2'd2;
    send(16'h0000, 1'b1);
    chk("carry_bits", 32'(pack(bo_a)), 32'h8020);
    chk("carry_count", 32'(fc_a), 32'd2);
    chk("carry_total", 32'(tf_a), 32'd2);
    do_flush();

    // Two requests on lane 3 invert it only once
    err_pos[3] = 2'd1;
    err_pos[4] = 2'd2;
    send(16'hFFFF, 1'b1);
    do_flush();
    chk("dup_bits", 32'(pack(bo_a)), 32'hFFF7);
    chk("dup_mask", 32'(fm_a), 32'h0008);
    chk("dup_count", 32'(fc_a), 32'd1);
    chk("dup_state", 32'(st_a == ST_EMPTY), 32'd1);
    chk("dup_total", 32'(tf_a), 32'd3);

    // Correction disabled on both frames
    err_pos[5] = 2'd1;
    send(16'h0000, 1'b0);
    err_pos[0] = 2'd2;
    send(16'h0000, 1'b0);
    chk("off_valid", 32'(ov_a), 32'd1);
    chk("off_bits", 32'(pack(bo_a)), 32'h0000);
    chk("off_total", 32'(tf_a), 32'd3);
    do_flush();

    // Code 3 then flush; second flush in EMPTY emits nothing
    err_pos[2] = 2'd3;
    send(16'h0000, 1'b1);
    do_flush();
    chk("both_bits", 32'(pack(bo_a)), 32'h0006);
    chk("both_state", 32'(st_a == ST_EMPTY), 32'd1);
    do_flush();
    chk("flush_empty_no_out", 32'(ov_a), 32'd0);

    // Saturation of the 4-bit counter
    for (int i = 0; i < W; i++) err_pos[i] = 2'd1;
    send(16'h0000, 1'b1);
    do_flush();
    chk("sat_count", 32'(fc_b), 32'd16);
    chk("sat_total4", 32'(tf_b), 32'd15);
    chk("sat_total16", 32'(tf_a), 32'd21);

    // Clear wins over a simultaneous increment
    err_pos[1] = 2'd1;
    send(16'h0001, 1'b1);
    clr_cnt = 1'b1;
    send(16'h0002, 1'b1);
    clr_cnt = 1'b0;
    chk("clr_valid", 32'(ov_a), 32'd1);
    chk("clr_total4", 32'(tf_b), 32'd0);
    chk("clr_total16", 32'(tf_a), 32'd0);

    // Reset while holding: held frame never emerges; carry after reset dropped
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_hold_state", 32'(st_a == ST_EMPTY), 32'd1);
    do_flush();
    chk("rst_hold_no_out", 32'(ov_a), 32'd0);
    err_pos[0] = 2'd2;
    send(16'h0000, 1'b1);
    chk("post_rst_no_out", 32'(ov_a), 32'd0);
    do_flush();
    chk("post_rst_bits", 32'(pack(bo_a)), 32'h0000);
    chk("post_rst_mask", 32'(fm_a), 32'h0000);

    // Randomized traffic, checked by the per-cycle compare
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 9) < 3);
      en_corr  = ($urandom_range(0, 9) < 8);
      clr_cnt  = ($urandom_range(0, 49) == 0);
      set_bits(W'($urandom));
      for (int i = 0; i < W; i++) begin
        err_pos[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      end
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    clr_cnt  = 1'b0;
    en_corr  = 1'b1;
    clear_codes();
    tick(); tick();
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
